// File: rtl/alu_seq_pkg.sv
// Shared encodings and widths for the sequenced ALU controller.
package alu_seq_pkg;

  localparam int unsigned DATA_W    = 4;
  localparam int unsigned RES_W     = 8;
  localparam int unsigned MUL_ITERS = 4;
  localparam int unsigned CNT_W     = 2;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_MUL  = 2'b10,
    OP_RSVD = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_MUL  = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  typedef struct packed {
    op_e               op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } req_t;

endpackage

// File: rtl/alu_seq_ctrl_alu.sv
// 4-bit add/subtract unit; s=1 computes in1-in2 through the same carry chain.
module ALU (
  input  logic       s,
  input  logic [3:0] in1,
  input  logic [3:0] in2,
  output logic [3:0] res,
  output logic       cout
);

  logic [3:0] in2_m;
  logic [4:0] acc;

  assign in2_m       = s ? ~in2 : in2;
  assign acc         = {1'b0, in1} + {1'b0, in2_m} + {4'b0000, s};
  assign {cout, res} = acc;

endmodule

// File: rtl/alu_seq_ctrl.sv
// Sequencer around one shared 4-bit ALU: single-cycle add/sub, 4-step shift-add multiply.
module alu_seq_ctrl
  import alu_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              ready,
  output logic              busy,
  output logic              done,
  output logic [RES_W-1:0]  result,
  output logic              err
);

  state_e            state_q, state_d;
  req_t              req_q;
  logic [DATA_W-1:0] hi_q, lo_q, hi_n, lo_n;
  logic [CNT_W-1:0]  cnt_q;
  logic              ready_d, busy_d, done_d;
  logic              accept, mul_last;

  logic              alu_s, alu_cout;
  logic [DATA_W-1:0] alu_in1, alu_in2, alu_res;
  logic [8:0]        step;

  assign accept   = (state_q == ST_IDLE) && start;
  assign mul_last = (cnt_q == CNT_W'(MUL_ITERS - 1));

  // ALU operands come only from latched state, so input changes in flight are harmless
  assign alu_s   = (state_q == ST_EXEC) && (req_q.op == OP_SUB);
  assign alu_in1 = (state_q == ST_MUL) ? hi_q : req_q.a;
  assign alu_in2 = (state_q == ST_MUL) ? req_q.a : req_q.b;

  ALU u_alu (
    .s    (alu_s),
    .in1  (alu_in1),
    .in2  (alu_in2),
    .res  (alu_res),
    .cout (alu_cout)
  );

  assign step = lo_q[0] ? ({alu_cout, alu_res, lo_q} >> 1) : ({1'b0, hi_q, lo_q} >> 1);
  assign hi_n = step[7:4];
  assign lo_n = step[3:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = (op_e'(op) == OP_MUL) ? ST_MUL : ST_EXEC;
      ST_EXEC: state_d = ST_DONE;
      ST_MUL:  if (mul_last) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ready_d = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    ready_d = (state_d == ST_IDLE);
    busy_d  = (state_d == ST_EXEC) || (state_d == ST_MUL);
    done_d  = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready <= 1'b1;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      ready <= ready_d;
      busy  <= busy_d;
      done  <= done_d;
    end
  end

  // Request capture, multiply iteration and result registration
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      cnt_q  <= '0;
      result <= '0;
      err    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            req_q <= '{op: op_e'(op), a: a, b: b};
            err   <= 1'b0;
            hi_q  <= '0;
            lo_q  <= b;
            cnt_q <= '0;
          end
        end
        ST_EXEC: begin
          case (req_q.op)
            OP_ADD:  result <= {3'b000, alu_cout, alu_res};
            OP_SUB:  result <= {4'b0000, alu_res};
            default: begin
              result <= '0;
              err    <= 1'b1;
            end
          endcase
        end
        ST_MUL: begin
          hi_q  <= hi_n;
          lo_q  <= lo_n;
          cnt_q <= cnt_q + CNT_W'(1);
          if (mul_last) result <= {hi_n, lo_n};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/alu_seq_ctrl.md
ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

Interface
REQ-001 Parameters: none; operand width is fixed at 4 bits by the ALU sub-module.
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request; sampled only when ready=1.
REQ-005 op  input  2  operation: 00 ADD, 01 SUB, 10 MUL, 11 reserved.
REQ-006 a  input  4  operand A (minuend / multiplicand).
REQ-007 b  input  4  operand B (subtrahend / multiplier).
REQ-008 ready  output  1  high only in IDLE; a request may be accepted.
REQ-009 busy  output  1  high in EXEC and MUL.
REQ-010 done  output  1  one-cycle pulse; result and err valid.
REQ-011 result  output  8  registered result, held until the next accepted request.
REQ-012 err  output  1  registered; set on a reserved-op request, cleared on the next accepted request.

Function
REQ-013 The FSM SHALL have exactly four states, IDLE, EXEC, MUL and DONE, with ready = (state==IDLE) and busy = (state==EXEC or MUL).
REQ-014 At an edge where ready=1 and start=1, the block SHALL latch op, a and b and clear err; op 00/01/11 go to EXEC, op 10 goes to MUL with iteration count=0, product hi=0 and product lo=b.
REQ-015 start SHALL be ignored in EXEC, MUL and DONE, with no effect on latched operands or outputs.
REQ-016 In EXEC, ADD SHALL drive the ALU with s=0 and register result={3'b000, cout, sum}.
REQ-017 In EXEC, SUB SHALL drive the ALU with s=1 and register result={4'b0000, diff}, where diff = (a-b) mod 16 and cout is forced to 0.
REQ-018 In EXEC, reserved op 11 SHALL register result=8'h00 and err=1.
REQ-019 EXEC SHALL last exactly one cycle and then go to DONE.
REQ-020 Each MUL cycle SHALL drive the ALU with s=0, in1=hi and in2=latched a.
REQ-021 In each MUL cycle, if lo[0]=1 then {c,hi',lo'} = {cout, sum, lo} >> 1; otherwise {c,hi',lo'} = {0, hi, lo} >> 1 (9-bit logical shift right).
REQ-022 MUL SHALL run exactly 4 iterations, counted by a 2-bit counter; on the 4th it SHALL register result={hi',lo'} (unsigned a*b) and go to DONE.
REQ-023 DONE SHALL assert done=1 for exactly one cycle and then return to IDLE unconditionally.
REQ-024 Latency: with capture at edge N, done SHALL be high after edge N+1 for ADD/SUB/reserved and after edge N+4 for MUL; the earliest next acceptance is edge N+3 (ADD/SUB/reserved) or N+6 (MUL).
REQ-025 Any change of a, b or op after acceptance SHALL NOT affect the operation in flight.
REQ-026 Boundaries: 15+15 gives 8'h1E; 0-1 gives 8'h0F; 15*15 gives 8'hE1; any operand times 0 gives 8'h00.

Reset
REQ-027 rst_n=0 SHALL immediately force state=IDLE, result=8'h00, err=0, done=0, iteration count=0, product hi/lo=0, ready=1 and busy=0, regardless of clk.
REQ-028 Reset asserted mid-MUL or mid-EXEC SHALL abort the operation, with no done pulse after release.
REQ-029 The first rising edge after rst_n deasserts SHALL be able to accept a request.

Structure
REQ-030 Package alu_seq_pkg SHALL hold the op encodings (OP_ADD, OP_SUB, OP_MUL, OP_RSVD), the state encoding, and MUL_ITERS=4.
REQ-031 The block SHALL instantiate exactly one existing 4-bit add/sub ALU sub-module (module ALU), shared between EXEC and MUL; no other adder is permitted.
REQ-032 The ALU select, in1 and in2 SHALL be driven from latched registers only, never from the raw inputs.

Verification
REQ-033 Reset, then ADD a=9, b=8 -> done after edge N+1, result=8'h11, err=0.
REQ-034 SUB a=3, b=5 -> result=8'h0E; SUB a=7, b=7 -> result=8'h00.
REQ-035 MUL a=15, b=15 -> busy for 4 cycles, done after edge N+4, result=8'hE1; MUL a=6, b=0 -> 8'h00.
REQ-036 During MUL a=3, b=5, pulse start with op=00 and change a/b -> the pulse is ignored, result=8'h0F, exactly one done.
REQ-037 Drop rst_n during MUL iteration 2 -> result=8'h00 and ready=1 immediately, and no done follows.
REQ-038 op=11 -> done with err=1 and result=8'h00; a following ADD a=1, b=1 -> err=0, result=8'h02.
